// File: rtl/sssp_gather_pkg.sv
// Shared graph package: vertex/update payloads, line geometry, mode encodings
// and the controller state type used by the SSSP gather engine.
package sssp_gather_pkg;

    localparam int unsigned VERTEX_W       = 64;
    localparam int unsigned VERTS_PER_LINE = 8;
    localparam int unsigned SLOT_W         = 3;
    localparam int unsigned LINE_W         = VERTEX_W * VERTS_PER_LINE;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_IMPORT = 2'd1;
    localparam logic [1:0] MODE_GATHER = 2'd2;
    localparam logic [1:0] MODE_EXPORT = 2'd3;

    typedef struct packed {
        logic [15:0] rsvd;
        logic [15:0] level;
        logic [31:0] weight;
    } vertex_t;

    typedef vertex_t [VERTS_PER_LINE-1:0] line_t;

    typedef struct packed {
        logic [31:0] dst;
        logic [31:0] weight;
    } update_t;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        DRAIN,
        EXPORT
    } state_t;

    // Vertex written when an update improves the stored distance.
    function automatic vertex_t relax_vertex(input logic [15:0] level, input logic [31:0] weight);
        vertex_t v;
        v.rsvd   = 16'd0;
        v.level  = level;
        v.weight = weight;
        return v;
    endfunction

endpackage

// File: rtl/gather_line_ram.sv
// Vertex line store: 2^LINES_W lines of 512 bits, one write port, one read
// port with a two-cycle registered read (address at T, data valid at T+2).
// A read and a write to the same line on the same edge return the old line.
// Ports: clk; rd_en/rd_addr -> rd_data; wr_en/wr_addr/wr_data.
module gather_line_ram
    import sssp_gather_pkg::*;
#(
    parameter int unsigned LINES_W = 5
) (
    input  logic               clk,
    input  logic               rd_en,
    input  logic [LINES_W-1:0] rd_addr,
    output logic [LINE_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [LINES_W-1:0] wr_addr,
    input  logic [LINE_W-1:0]  wr_data
);
    localparam int unsigned DEPTH = 1 << LINES_W;

    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rd_q1;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Two-stage read pipeline.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_q1 <= mem[rd_addr];
        end
        rd_data <= rd_q1;
    end

endmodule

// File: rtl/sssp_gather.sv
// SSSP gather engine for one vertex partition. Imports vertex lines into a
// local line RAM, applies (dst, weight) relaxation updates with a 4-stage
// read-modify-write pipeline, and exports the partition as a line stream.
// Ports: clk, rst (sync, active-high); control/current_level mode inputs;
// line_in/line_addr/line_valid import; update_in/update_valid/last_input_in
// gather; line_out/line_out_addr/line_out_valid/line_out_ready export;
// done pulse, changed_cnt, drop_cnt statistics.
// Build option: define SSSP_GATHER_STATS_EN to count discarded updates in
// drop_cnt; otherwise drop_cnt is constant zero.
module sssp_gather
    import sssp_gather_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        control,
    input  logic [15:0]       current_level,
    input  logic [LINE_W-1:0] line_in,
    input  logic [31:0]       line_addr,
    input  logic              line_valid,
    input  logic [63:0]       update_in,
    input  logic              update_valid,
    input  logic              last_input_in,
    output logic [LINE_W-1:0] line_out,
    output logic [31:0]       line_out_addr,
    output logic              line_out_valid,
    input  logic              line_out_ready,
    output logic              done,
    output logic [31:0]       changed_cnt,
    output logic [31:0]       drop_cnt
);
    localparam int unsigned LINES_W  = ADDR_W - SLOT_W;
    localparam int unsigned PREFIX_W = 32 - LINES_W;
    localparam int unsigned TAG_W    = 32 - ADDR_W;
    localparam int unsigned PTR_W    = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned CNT_W    = $clog2(FIFO_D + 1);
    localparam int unsigned OCC_W    = CNT_W + 2;

    state_t state, state_d;
    logic   done_d;

    logic [PREFIX_W-1:0] prefix;
    update_t             upd;
    logic                import_fire, gather_fire, upd_hit, gather_issue;

    // RAM ports
    logic               ram_rd_en, ram_wr_en;
    logic [LINES_W-1:0] ram_rd_addr, ram_wr_addr;
    logic [LINE_W-1:0]  ram_rd_data, ram_wr_data;

    // Gather pipeline (s1 = T+1, s2 = T+2, s3 = T+3) and write history
    logic               s1_v, s2_v, s3_v, s3_wr, h1_v, h2_v;
    logic [LINES_W-1:0] s1_idx, s2_idx, s3_idx, h1_idx, h2_idx;
    logic [SLOT_W-1:0]  s1_slot, s2_slot;
    logic [31:0]        s1_w, s2_w;
    logic [15:0]        s1_lvl, s2_lvl;
    line_t              s3_line, h1_line, h2_line;
    line_t              s2_base, s2_line;
    vertex_t            s2_old;
    logic               s2_better;

    // Export read engine and output buffer
    logic               exp_v1, exp_v2, exp_all, exp_issue, exp_finish;
    logic [LINES_W-1:0] exp_idx, exp_idx1, exp_idx2;
    logic [OCC_W-1:0]   exp_occ;
    logic [LINE_W-1:0]  fifo_line [FIFO_D];
    logic [LINES_W-1:0] fifo_idx  [FIFO_D];
    logic [PTR_W-1:0]   fifo_rp, fifo_wp;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               out_pop, out_load, fifo_pop, fifo_push;

    logic               stats_clr;

    assign upd          = update_t'(update_in);
    assign import_fire  = (state == IDLE) && (control == MODE_IMPORT) && line_valid;
    assign gather_fire  = (state == GATHER) && (control == MODE_GATHER) && update_valid;
    assign upd_hit      = (upd.dst[31:ADDR_W] == prefix[TAG_W-1:0]);
    assign gather_issue = gather_fire && upd_hit;
    assign stats_clr    = (state == IDLE) && (state_d == GATHER);

    gather_line_ram #(
        .LINES_W (LINES_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    // RAM port sharing: import and gather writes never overlap (import only in IDLE).
    assign ram_rd_en   = gather_issue || exp_issue;
    assign ram_rd_addr = (state == EXPORT) ? exp_idx : upd.dst[ADDR_W-1:SLOT_W];
    assign ram_wr_en   = import_fire || (s3_v && s3_wr);
    assign ram_wr_addr = import_fire ? line_addr[LINES_W-1:0] : s3_idx;
    assign ram_wr_data = import_fire ? line_in : LINE_W'(s3_line);

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            done  <= done_d;
        end
    end

    // Controller next state.
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (control == MODE_GATHER) begin
                    state_d = GATHER;
                end else if (control == MODE_EXPORT) begin
                    state_d = EXPORT;
                end
            end
            GATHER: begin
                if (gather_fire && last_input_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_v && !s2_v && !s3_v) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            EXPORT: begin
                if (exp_finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Partition prefix latched by import.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefix <= '0;
        end else if (import_fire) begin
            prefix <= line_addr[31:LINES_W];
        end
    end

    // Stage-2 merge: newest in-flight copy of the line wins over RAM data,
    // covering writes at the current edge (s3) and the two previous edges.
    always_comb begin
        s2_base = line_t'(ram_rd_data);
        if (h2_v && (h2_idx == s2_idx)) s2_base = h2_line;
        if (h1_v && (h1_idx == s2_idx)) s2_base = h1_line;
        if (s3_v && (s3_idx == s2_idx)) s2_base = s3_line;
        s2_old    = s2_base[s2_slot];
        s2_better = (s2_w < s2_old.weight);
        s2_line   = s2_base;
        if (s2_better) begin
            s2_line[s2_slot] = relax_vertex(s2_lvl, s2_w);
        end
    end

    // Pipeline and history valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            s3_v  <= 1'b0;
            s3_wr <= 1'b0;
            h1_v  <= 1'b0;
            h2_v  <= 1'b0;
        end else begin
            s1_v  <= gather_issue;
            s2_v  <= s1_v;
            s3_v  <= s2_v;
            s3_wr <= s2_v && s2_better;
            h1_v  <= s3_v;
            h2_v  <= h1_v;
        end
    end

    // Pipeline and export datapath payloads.
    always_ff @(posedge clk) begin
        s1_idx   <= upd.dst[ADDR_W-1:SLOT_W];
        s1_slot  <= upd.dst[SLOT_W-1:0];
        s1_w     <= upd.weight;
        s1_lvl   <= current_level + 16'd1;
        s2_idx   <= s1_idx;
        s2_slot  <= s1_slot;
        s2_w     <= s1_w;
        s2_lvl   <= s1_lvl;
        s3_idx   <= s2_idx;
        s3_line  <= s2_line;
        h1_idx   <= s3_idx;
        h1_line  <= s3_line;
        h2_idx   <= h1_idx;
        h2_line  <= h1_line;
        exp_idx1 <= exp_idx;
        exp_idx2 <= exp_idx1;
        if (fifo_push) begin
            fifo_line[fifo_wp] <= ram_rd_data;
            fifo_idx[fifo_wp]  <= exp_idx2;
        end
    end

    // Export flow control: occupancy counts reads in flight plus buffered lines.
    assign exp_occ    = OCC_W'(exp_v1) + OCC_W'(exp_v2) + OCC_W'(fifo_cnt) + OCC_W'(line_out_valid);
    assign exp_issue  = (state == EXPORT) && !exp_all && (exp_occ < OCC_W'(FIFO_D));
    assign out_pop    = line_out_valid && line_out_ready;
    assign out_load   = !line_out_valid || out_pop;
    assign fifo_pop   = out_load && (fifo_cnt != '0);
    assign fifo_push  = exp_v2 && !(out_load && (fifo_cnt == '0));
    assign exp_finish = exp_all && !exp_v1 && !exp_v2 && (fifo_cnt == '0) && out_load;

    // Export read issue, FIFO pointers and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_v1         <= 1'b0;
            exp_v2         <= 1'b0;
            exp_idx        <= '0;
            exp_all        <= 1'b0;
            fifo_rp        <= '0;
            fifo_wp        <= '0;
            fifo_cnt       <= '0;
            line_out_valid <= 1'b0;
            line_out       <= '0;
            line_out_addr  <= '0;
        end else begin
            exp_v1 <= exp_issue;
            exp_v2 <= exp_v1;
            if (state == IDLE) begin
                exp_idx <= '0;
                exp_all <= 1'b0;
            end else if (exp_issue) begin
                exp_idx <= exp_idx + LINES_W'(1);
                if (exp_idx == '1) begin
                    exp_all <= 1'b1;
                end
            end
            if (fifo_push) begin
                fifo_wp <= (fifo_wp == PTR_W'(FIFO_D - 1)) ? '0 : fifo_wp + PTR_W'(1);
            end
            if (fifo_pop) begin
                fifo_rp <= (fifo_rp == PTR_W'(FIFO_D - 1)) ? '0 : fifo_rp + PTR_W'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (fifo_pop && !fifo_push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
            if (out_load) begin
                if (fifo_cnt != '0) begin
                    line_out       <= fifo_line[fifo_rp];
                    line_out_addr  <= {prefix, fifo_idx[fifo_rp]};
                    line_out_valid <= 1'b1;
                end else if (exp_v2) begin
                    line_out       <= ram_rd_data;
                    line_out_addr  <= {prefix, exp_idx2};
                    line_out_valid <= 1'b1;
                end else begin
                    line_out_valid <= 1'b0;
                end
            end
        end
    end

    // Improved-vertex counter, saturating.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            changed_cnt <= '0;
        end else if (s3_v && s3_wr && (changed_cnt != '1)) begin
            changed_cnt <= changed_cnt + 32'd1;
        end
    end

`ifdef SSSP_GATHER_STATS_EN
    logic [31:0] drop_q;

    // Discarded-update counter, saturating.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            drop_q <= '0;
        end else if (gather_fire && !upd_hit && (drop_q != '1)) begin
            drop_q <= drop_q + 32'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sssp_gather.sv
// Scoreboard bench for sssp_gather: import, gather with forwarding cases,
// export under a 1,0,0,1 ready pattern, and reset during an update.
module tb_sssp_gather;
    import sssp_gather_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   control;
    logic [15:0]  current_level;
    logic [511:0] line_in;
    logic [31:0]  line_addr;
    logic         line_valid;
    logic [63:0]  update_in;
    logic         update_valid;
    logic         last_input_in;
    logic [511:0] line_out;
    logic [31:0]  line_out_addr;
    logic         line_out_valid;
    logic         line_out_ready;
    logic         done;
    logic [31:0]  changed_cnt;
    logic [31:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
    } exp_line_t;

    typedef struct {
        logic [31:0] changed;
        logic [31:0] drop;
    } exp_done_t;

    exp_line_t    line_q[$];
    exp_done_t    done_q[$];
    logic [511:0] model [32];
    logic         rdy_pat [4];
    logic [31:0]  exp_drop;

    sssp_gather dut (
        .clk            (clk),
        .rst            (rst),
        .control        (control),
        .current_level  (current_level),
        .line_in        (line_in),
        .line_addr      (line_addr),
        .line_valid     (line_valid),
        .update_in      (update_in),
        .update_valid   (update_valid),
        .last_input_in  (last_input_in),
        .line_out       (line_out),
        .line_out_addr  (line_out_addr),
        .line_out_valid (line_out_valid),
        .line_out_ready (line_out_ready),
        .done           (done),
        .changed_cnt    (changed_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] vtx(input logic [15:0] r, input logic [15:0] l, input logic [31:0] w);
        return {r, l, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_upd(input logic [31:0] dst, input logic [31:0] w, input logic [15:0] lvl,
                            input logic last);
        update_in     = {dst, w};
        current_level = lvl;
        last_input_in = last;
        update_valid  = 1'b1;
        tick();
        update_valid  = 1'b0;
        last_input_in = 1'b0;
    endtask

    task automatic expect_export(input logic [31:0] chg, input logic [31:0] drp);
        exp_line_t e;
        exp_done_t d;
        for (int l = 0; l < 32; l++) begin
            e.addr = 32'(l);
            e.data = model[l];
            line_q.push_back(e);
        end
        d.changed = chg;
        d.drop    = drp;
        done_q.push_back(d);
    endtask

    task automatic wait_empty(input int budget, input string nm);
        int n = 0;
        while ((line_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (line_q.size() != 0 || done_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: lines_left=%0d dones_left=%0d", nm, line_q.size(), done_q.size());
            line_q.delete();
            done_q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Ready pattern driver.
    initial begin
        int k = 0;
        rdy_pat[0] = 1'b1;
        rdy_pat[1] = 1'b0;
        rdy_pat[2] = 1'b0;
        rdy_pat[3] = 1'b1;
        line_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            line_out_ready = rdy_pat[k % 4];
            k++;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT transfers a line or pulses done.
    always @(negedge clk) begin
        if (!rst) begin
            if (line_out_valid && line_out_ready) begin
                if (line_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_line: got addr %h expected none", line_out_addr);
                end else begin
                    exp_line_t e;
                    e = line_q.pop_front();
                    chk32("line_out_addr", line_out_addr, e.addr);
                    chk_line("line_out", line_out, e.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    exp_done_t d;
                    d = done_q.pop_front();
                    chk32("done_changed_cnt", changed_cnt, d.changed);
                    chk32("done_drop_cnt", drop_cnt, d.drop);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SSSP_GATHER_STATS_EN
        exp_drop = 32'd1;
`else
        exp_drop = 32'd0;
`endif
        rst           = 1'b1;
        control       = MODE_IDLE;
        current_level = '0;
        line_in       = '0;
        line_addr     = '0;
        line_valid    = 1'b0;
        update_in     = '0;
        update_valid  = 1'b0;
        last_input_in = 1'b0;
        for (int l = 0; l < 32; l++) begin
            for (int s = 0; s < 8; s++) begin
                model[l][s*64 +: 64] = vtx(16'h00AA, 16'h0001, (l == 0) ? 32'd100 : 32'(1000 + l * 8 + s));
            end
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk32("rst_line_out_valid", 32'(line_out_valid), 32'd0);
        chk32("rst_done", 32'(done), 32'd0);
        chk32("rst_changed_cnt", changed_cnt, 32'd0);
        chk32("rst_drop_cnt", drop_cnt, 32'd0);
        chk32("rst_line_out_addr", line_out_addr, 32'd0);
        chk_line("rst_line_out", line_out, 512'd0);
        tick();

        // Import all 32 lines, prefix 0
        control = MODE_IMPORT;
        for (int l = 0; l < 32; l++) begin
            line_addr  = 32'(l);
            line_in    = model[l];
            line_valid = 1'b1;
            tick();
        end
        line_valid = 1'b0;

        // Update strobe outside gather mode is ignored
        control = MODE_IDLE;
        send_upd(32'd3, 32'd0, 16'd0, 1'b0);

        // Gather session
        begin
            exp_done_t d;
            d.changed = 32'd6;
            d.drop    = exp_drop;
            done_q.push_back(d);
        end
        control = MODE_GATHER;
        tick();
        send_upd(32'd2, 32'd40, 16'd3, 1'b0);       // slot2: 100 -> {4,40}
        send_upd(32'd5, 32'd50, 16'd3, 1'b0);       // same line back-to-back
        send_upd(32'd5, 32'd30, 16'd3, 1'b0);
        send_upd(32'd5, 32'd60, 16'd3, 1'b0);       // keeps 30
        send_upd(32'h1000, 32'd1, 16'd3, 1'b0);     // outside partition
        send_upd(32'd16, 32'd10, 16'd7, 1'b0);      // 1016 -> 10
        line_addr  = 32'd4;                          // import strobe in gather mode: ignored
        line_in    = '1;
        line_valid = 1'b1;
        tick();
        line_valid = 1'b0;
        send_upd(32'd17, 32'd5, 16'd7, 1'b0);       // 1017 -> 5, one-cycle gap
        tick();
        tick();
        send_upd(32'd16, 32'd11, 16'd7, 1'b0);      // two-cycle gap, 11 > 10
        send_upd(32'd40, 32'd7, 16'hFFFF, 1'b0);    // level wraps to 0
        send_upd(32'd41, 32'd1041, 16'd2, 1'b0);    // equal weight: no change
        control = MODE_GATHER;
        update_in     = {32'd255, 32'd2000};
        current_level = 16'd1;
        last_input_in = 1'b1;
        update_valid  = 1'b1;
        tick();
        update_valid  = 1'b0;
        last_input_in = 1'b0;
        control       = MODE_IDLE;
        wait_empty(200, "gather_done");

        model[0][2*64 +: 64] = vtx(16'd0, 16'd4, 32'd40);
        model[0][5*64 +: 64] = vtx(16'd0, 16'd4, 32'd30);
        model[2][0*64 +: 64] = vtx(16'd0, 16'd8, 32'd10);
        model[2][1*64 +: 64] = vtx(16'd0, 16'd8, 32'd5);
        model[5][0*64 +: 64] = vtx(16'd0, 16'd0, 32'd7);

        // Export with toggling ready
        expect_export(32'd6, exp_drop);
        control = MODE_EXPORT;
        tick();
        control = MODE_IDLE;
        wait_empty(2000, "export1");

        // Reset the cycle after an accepted update
        control = MODE_GATHER;
        tick();
        send_upd(32'd3, 32'd1, 16'd5, 1'b0);
        rst     = 1'b1;
        control = MODE_IDLE;
        @(posedge clk);
        @(negedge clk);
        chk32("midrst_line_out_valid", 32'(line_out_valid), 32'd0);
        chk32("midrst_done", 32'(done), 32'd0);
        chk32("midrst_changed_cnt", changed_cnt, 32'd0);
        chk32("midrst_drop_cnt", drop_cnt, 32'd0);
        chk32("midrst_line_out_addr", line_out_addr, 32'd0);
        chk_line("midrst_line_out", line_out, 512'd0);
        rst = 1'b0;
        tick();

        // RAM must be unchanged by the cancelled update
        expect_export(32'd0, 32'd0);
        control = MODE_EXPORT;
        tick();
        control = MODE_IDLE;
        wait_empty(2000, "export2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sssp_gather.md
SSSP_GATHER -- requirements
Module: sssp_gather

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of vertices held per partition (minimum 4).
REQ-002 SHALL have parameter FIFO_D, default 4, meaning export output buffer depth in lines.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: control  in  2  mode (0 idle, 1 import, 2 gather, 3 export); current_level  in  16  iteration level.
REQ-005 SHALL have ports: line_in  in  512  vertex line for import; line_addr  in  32  global line index; line_valid  in  1  import strobe.
REQ-006 SHALL have ports: update_in  in  64  {dst[63:32], weight[31:0]}; update_valid  in  1  update strobe; last_input_in  in  1  final update marker.
REQ-007 SHALL have ports: line_out  out  512; line_out_addr  out  32; line_out_valid  out  1; line_out_ready  in  1 (export stream).
REQ-008 SHALL have ports: done  out  1  one-cycle pulse; changed_cnt  out  32  improved-vertex count; drop_cnt  out  32  (stats only).

Function
REQ-009 Vertex SHALL be 64 bits {rsvd[15:0], level[15:0], weight[31:0]}; 8 per line; slot = vertex index[2:0].
REQ-010 Import: control==1 & line_valid SHALL write line_in to RAM line line_addr[ADDR_W-4:0] and latch prefix line_addr[31:ADDR_W-3].
REQ-011 Gather: control==2 & update_valid SHALL accept one update per cycle; no backpressure.
REQ-012 Update whose dst[31:ADDR_W] != latched prefix SHALL be discarded without RAM access (counts in drop_cnt).
REQ-013 Accepted update SHALL issue line read at T, receive data at T+2, write modified line at T+3.
REQ-014 If update weight < stored weight (unsigned): slot SHALL become {0, current_level+1 (mod 2^16), update weight}, changed_cnt +1; otherwise no write.
REQ-015 Updates to a line in flight at T+1..T+3 SHALL be forwarded so result equals strict in-order application (back-to-back same dst keeps minimum).
REQ-016 FSM SHALL have states IDLE, GATHER, DRAIN, EXPORT; IDLE->GATHER on control==2; GATHER->DRAIN on accepted last_input_in; DRAIN->IDLE after pipeline empty, asserting done for one cycle.
REQ-017 changed_cnt SHALL clear on IDLE->GATHER; saturate at 0xFFFFFFFF.
REQ-018 IDLE->EXPORT on control==3; lines 0..2^(ADDR_W-3)-1 SHALL be emitted in order, line_out_addr = {prefix, index}; done pulses after last handshake; return IDLE.
REQ-019 Transfer SHALL occur when line_out_valid & line_out_ready; reads SHALL issue only while in-flight+buffered < FIFO_D; no line lost or duplicated under any ready pattern.
REQ-020 Import or update strobes outside their mode SHALL be ignored.

Reset
REQ-021 rst SHALL set state IDLE, line_out_valid 0, done 0, line_out 0, line_out_addr 0, counters 0, pipeline valids 0, FIFO empty, prefix 0.
REQ-022 rst mid-operation SHALL cancel in-flight writes not yet at T+3; RAM contents need not be cleared.

Configuration
REQ-023 Macro SSSP_GATHER_STATS_EN defined: drop_cnt counts discarded updates (saturating, cleared with changed_cnt); undefined: drop_cnt tied to 0 and its counter absent.

Structure
REQ-024 vertex_t, update_t, mode constants and line geometry (8 vertices/line) SHALL live in the shared graph package.
REQ-025 Line RAM SHALL be sub-module gather_line_ram (2^(ADDR_W-3) x 512, 2-cycle registered read, one write port).

Verification
REQ-026 Import line 0 with slot2 weight 100; gather update {dst=2, w=40}, level 3 -> slot2 = {level 4, weight 40}, changed_cnt 1.
REQ-027 Updates dst=5 w=50 then w=30 then w=60 on consecutive cycles (stored 100) -> final weight 30, changed_cnt 2.
REQ-028 Prefix 0, update dst=0x1000 -> RAM unchanged, drop_cnt 1 (STATS_EN) / 0 (without).
REQ-029 last_input_in with final update -> done pulses exactly once after the T+3 write, state IDLE.
REQ-030 Export ADDR_W=8 with line_out_ready toggling 1,0,0,1 -> 32 lines, addresses 0..31 in order, contents match RAM, no duplicates.
REQ-031 rst asserted cycle after accepted update -> no RAM write, all outputs at reset values next cycle.
